// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the program counter slice
package pc_pkg;
    localparam int         PC_W_DEF     = 8;
    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;

    typedef enum logic [2:0] {RET, CALL, JUMP, BRANCH, SEQ} pc_src_e;
endpackage

// File: rtl/program_counter_if.sv
// program_counter_if: control/status bundle between the core and the program counter
interface program_counter_if import pc_pkg::*; #(
    parameter int PC_W = PC_W_DEF
) ();
    logic            en;
    logic [PC_W-1:0] pcCount;
    logic [PC_W-1:0] addedCount;
    logic            branch_take;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] jump_target;
    logic            halt;
    logic            resume;
    logic            pc_valid;
    logic            halted;
    logic            stk_ovf;
    logic            stk_unf;

    modport master (
        output en, addedCount, branch_take, branch_target, jump, call, ret, jump_target, halt, resume,
        input  pcCount, pc_valid, halted, stk_ovf, stk_unf
    );

    modport slave (
        input  en, addedCount, branch_take, branch_target, jump, call, ret, jump_target, halt, resume,
        output pcCount, pc_valid, halted, stk_ovf, stk_unf
    );
endinterface

// File: rtl/program_counter_return_stack.sv
// return_stack: LIFO of return addresses; push/pop past the bounds are dropped
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr_q, ptr_d, top_idx;
    logic [W-1:0]  mem_q [DEPTH];

    assign full_o  = ptr_q == PW'(DEPTH);
    assign empty_o = ptr_q == '0;
    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx[AW-1:0]];

    // pointer moves only on an accepted push or pop
    always_comb begin
        ptr_d = push_i && !full_o ? ptr_q + PW'(1) : pop_i && !empty_o ? ptr_q - PW'(1) : ptr_q;
    end

    // pointer register, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // storage needs no reset; an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/program_counter.sv
// program_counter: PC register, next-PC select and BOOT/RUN/HALT control.
// Define CALL_STACK_EN to build the hardware call/return stack.
module program_counter import pc_pkg::*; #(
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEF),
    parameter int              STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    program_counter_if.slave  bus
);
    pc_state_e       state_q;
    pc_src_e         src;
    logic [PC_W-1:0] pc_q, pc_d, stk_top;
    logic            valid_q, halted_q, ovf_q, unf_q, ovf_d, unf_d;
    logic            advance, push, pop, use_ret, stk_full, stk_empty;

`ifdef CALL_STACK_EN
    assign use_ret = bus.ret;

    return_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.addedCount),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    logic unused_cfg;
    assign use_ret    = 1'b0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign stk_top    = '0;
    assign unused_cfg = ^{STACK_DEPTH, bus.ret, pop};
`endif

    // priority-ordered source select and next-PC mux; +1 comes from the external adder
    always_comb begin
        src     = use_ret ? RET : bus.call ? CALL : bus.jump ? JUMP : bus.branch_take ? BRANCH : SEQ;
        pc_d    = src == RET ? (stk_empty ? bus.addedCount : stk_top) :
                  (src == CALL || src == JUMP) ? bus.jump_target :
                  src == BRANCH ? bus.branch_target : bus.addedCount;
        advance = state_q == RUN && !bus.halt && bus.en;
        push    = advance && src == CALL;
        pop     = advance && src == RET;
        ovf_d   = ovf_q | (push & stk_full);
        unf_d   = unf_q | (pop & stk_empty);
    end

    // control FSM with registered PC, status and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (bus.halt) begin
                        state_q  <= HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (bus.en) begin
                        pc_q  <= pc_d;
                        ovf_q <= ovf_d;
                        unf_q <= unf_d;
                    end
                end
                HALT: begin
                    if (bus.resume && !bus.halt) begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.pcCount  = pc_q;
    assign bus.pc_valid = valid_q;
    assign bus.halted   = halted_q;
    assign bus.stk_ovf  = ovf_q;
    assign bus.stk_unf  = unf_q;
endmodule

// File: doc/program_counter.md
# program_counter

8-bit program-counter register and next-PC selector for the single-cycle core. It drives the current PC to the fetch path and to `pcAndOneAdder`, and takes the adder's `addedCount` back as its sequential next-PC. Each enabled cycle it selects one of four sources for the next PC: sequential, branch, jump, or return address. It also provides a halt/resume state machine and an optional hardware call/return stack.

## Interface
Parameters:
- `PC_W`, 8: PC width. Must match the adder width.
- `RESET_PC`, 8'h00: PC value loaded on reset.
- `STACK_DEPTH`, 4: return-stack entries. Only used when `CALL_STACK_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  advance enable. When 0, the PC holds (stall).
- `pcCount`  out  PC_W  current PC, fed to the adder and to instruction fetch.
- `addedCount`  in  PC_W  `pcCount + 1`, returned from the adder.
- `branch_take`  in  1  take a conditional branch.
- `branch_target`  in  PC_W  branch destination.
- `jump`  in  1  unconditional jump.
- `call`  in  1  jump plus push of the return address.
- `ret`  in  1  pop the return address and load it into the PC.
- `jump_target`  in  PC_W  destination for `jump` and `call`.
- `halt`  in  1  request halt.
- `resume`  in  1  leave the halted state.
- `pc_valid`  out  1  `pcCount` holds a fetchable address this cycle.
- `halted`  out  1  FSM is in HALT.
- `stk_ovf`  out  1  sticky flag: a push was attempted while the stack was full.
- `stk_unf`  out  1  sticky flag: a pop was attempted while the stack was empty.

## Operation
FSM states are BOOT, RUN and HALT.

Reset, sampled on a `clk` edge with `rst_n`=0:
- Outputs: `pcCount`=`RESET_PC`, state=BOOT, `pc_valid`=0, `halted`=0, `stk_ovf`=0, `stk_unf`=0.
- Stack pointer is set to 0. Reset takes priority over every other input, including during a halt or mid-call.

State transitions:
- BOOT -> RUN unconditionally on the next edge. The PC is unchanged, so the first fetch is `RESET_PC`.
- RUN, `halt`=1 -> HALT. The PC holds. `halt` wins over every redirect in the same cycle.
- HALT, `resume`=1 -> RUN. The PC is unchanged. `halt` and `resume` together in HALT: remain in HALT.
- In HALT, all redirect inputs and `en` are ignored.

In RUN with `en`=1, the next PC is chosen in strict priority order:
1. `ret`: PC = top of stack, then pop.
2. `call`: push `addedCount`, then PC = `jump_target`.
3. `jump`: PC = `jump_target`.
4. `branch_take`: PC = `branch_target`.
5. Otherwise: PC = `addedCount`.

In RUN with `en`=0, everything holds: PC, stack and flags.

Arithmetic: all PC values are PC_W bits and wrap modulo 2^PC_W. 8'hFF advances to 8'h00 through the adder, and the block applies no saturation.

Stack boundaries:
- `call` with the stack full: the push is dropped, the jump is still taken, and `stk_ovf` is set.
- `ret` with the stack empty: PC = `addedCount`, and `stk_unf` is set.
- Sticky flags clear only on reset.

`pc_valid` is 1 in RUN and 0 in BOOT and HALT.

## Timing
- Next-PC selection is combinational. `pcCount` is registered and updates on the same edge that samples the controls, so a redirect takes effect with 1-cycle latency.
- `halted`, `pc_valid` and the flags are registered and change on the edge after the causing input.
- The block has no combinational path from any input to `pcCount`.
- `addedCount` is combinational from `pcCount`. The block closes the `pcCount` -> adder -> next-PC mux -> register loop in a single cycle.

## Configuration
- `CALL_STACK_EN` defined: the return stack is built as a LIFO of `STACK_DEPTH` x `PC_W` registers with a `$clog2(STACK_DEPTH+1)`-bit pointer.
- `CALL_STACK_EN` undefined: no stack storage is built.
  - `call` behaves exactly as `jump`.
  - `ret` is ignored, and the priority falls through to the next source.
  - `stk_ovf` and `stk_unf` are tied to 0.

## Structure
- Shared package `pc_pkg` holds:
  - the FSM state typedef (BOOT/RUN/HALT, 2 bits);
  - the next-PC source enum (RET, CALL, JUMP, BRANCH, SEQ);
  - `PC_W` and `RESET_PC` defaults.
- One sub-module, `return_stack`: push/pop/full/empty, instantiated only under `CALL_STACK_EN`.
- The adder stays external. This block never computes +1 itself.

## Test plan
- Reset release: `RESET_PC`=8'h10, no controls. Expect `pcCount` sequence 10, 10 (BOOT), 11, 12 with `pc_valid` 0, 1, 1, 1.
- Wrap and stall: run from 8'hFE with `en` toggled 1, 0, 1. Expect `pcCount` FE -> FF, hold FF, then -> 00.
- Priority: `jump`=1 to 8'h40 and `branch_take`=1 to 8'h80 in the same cycle. Expect `pcCount`=40. Then `halt` with `jump` asserted: expect PC holds, `halted`=1, and `resume` returns to RUN at the same PC.
- Call/return, with the macro defined: `call` at PC 8'h05 to 8'h30, run 2 cycles, then `ret`. Expect PC 30, 31, 32, then 06.
- Stack overflow/underflow, `STACK_DEPTH`=4: issue 5 calls. Expect the 5th call still jumps and `stk_ovf`=1. Then 5 rets: the first 4 return addresses come back in LIFO order, and the 5th gives PC = `addedCount` with `stk_unf`=1.
- Reset mid-halt and macro off:
  - Assert `rst_n`=0 while in HALT. Expect BOOT, `halted`=0, and both flags clear.
  - With the macro undefined, `call` behaves as a jump, `ret` at PC 8'h20 gives 8'h21, and both flags stay 0.
